// File: rtl/yd_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : yd_fetch_decode
//  Purpose  : Instruction fetch/decode stage in front of the register file.
//             Fetches 16-bit instructions at the register-file PC, buffers
//             them in a small queue, decodes the head into register-file
//             addresses, and holds the PC across a PC-writing (branch)
//             instruction until execute reports the write.
//  Ports    : clk, rst (async, active low)
//             pc_i / jpc_o           - register-file PC and PC-hold control
//             imem_*                 - single-outstanding instruction fetch
//             stall_i, br_done_i     - execute-stage back-pressure / PC write
//             dec_valid, dec_pc, op, waddr0, we0, raddr0, raddr1, imm
//                                    - registered decode outputs
//  Revision : 1.0 - initial release
// ============================================================================
module yd_fetch_decode #(
    parameter int         QDEPTH = 2,
    parameter logic [3:0] NOP_OP = 4'h0,
    parameter logic [3:0] LDI_OP = 4'hE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_i,
    output logic        jpc_o,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    input  logic        stall_i,
    input  logic        br_done_i,
    output logic        dec_valid,
    output logic [15:0] dec_pc,
    output logic [3:0]  op,
    output logic [3:0]  waddr0,
    output logic        we0,
    output logic [3:0]  raddr0,
    output logic [3:0]  raddr1,
    output logic [15:0] imm
);
    localparam int          PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CW   = PW + 1;
    localparam logic [CW:0] QD_C = (CW+1)'(QDEPTH);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_BRANCH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [15:0]   q_instr [QDEPTH];
    logic [15:0]   q_pc    [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          outstanding;
    logic          discard;
    logic [15:0]   out_pc;

    logic [CW:0]   reserved;
    logic          accept;
    logic          resp;
    logic          push;
    logic          load;
    logic          branch_take;
    logic          out_next;
    logic [15:0]   head_instr;

    assign head_instr = q_instr[rd_ptr];
    assign reserved   = {1'b0, count} + {{CW{1'b0}}, outstanding};

    // Only one fetch may be in flight; a new request is allowed while the
    // current one is being answered this cycle, which keeps back-to-back
    // fetches streaming. Gating with rst keeps the PC held during reset.
    assign imem_req  = rst & (state == ST_FETCH) & (reserved < QD_C) & ~discard
                       & (~outstanding | imem_valid);
    assign accept    = imem_req & imem_ready;
    assign jpc_o     = ~accept;
    assign imem_addr = pc_i;

    // Responses without a request in flight are ignored.
    assign resp     = imem_valid & outstanding;
    assign push     = resp & ~discard;
    assign load     = (count != '0) & (~dec_valid | ~stall_i);
    assign out_next = resp ? accept : (outstanding | accept);

    assign branch_take = load & (state == ST_FETCH)
                         & (head_instr[15:12] != NOP_OP)
                         & (head_instr[11:8] == 4'hF);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (branch_take) state_nxt = ST_BRANCH;
            ST_BRANCH: if (br_done_i)   state_nxt = ST_FETCH;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // Queue payload: no reset needed, validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (push && !branch_take) begin
            q_instr[wr_ptr] <= imem_data;
            q_pc[wr_ptr]    <= out_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FETCH;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            out_pc      <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_next;
            if (accept) out_pc <= pc_i;
            if (resp)   discard <= 1'b0;
            if (branch_take) begin
                // Everything younger than the branch is dropped: queued
                // entries now, and whatever fetch is still in flight later.
                discard <= out_next;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (load) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(load);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_valid <= 1'b0;
            dec_pc    <= '0;
            op        <= '0;
            waddr0    <= '0;
            we0       <= 1'b0;
            raddr0    <= '0;
            raddr1    <= '0;
            imm       <= '0;
        end else if (load) begin
            dec_valid <= 1'b1;
            dec_pc    <= q_pc[rd_ptr];
            op        <= head_instr[15:12];
            waddr0    <= head_instr[11:8];
            we0       <= (head_instr[15:12] != NOP_OP);
            raddr0    <= head_instr[7:4];
            raddr1    <= head_instr[3:0];
            imm       <= (head_instr[15:12] == LDI_OP)
                         ? {{8{head_instr[7]}}, head_instr[7:0]} : 16'h0000;
        end else if (!stall_i) begin
            // Current instruction consumed with nothing behind it.
            dec_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_yd_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_yd_fetch_decode
//  Purpose  : Directed self-checking bench for yd_fetch_decode with a
//             one-cycle-latency instruction memory and a PC register model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_yd_fetch_decode;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_i;
    logic        jpc_o;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        stall_i;
    logic        br_done_i;
    logic        dec_valid;
    logic [15:0] dec_pc;
    logic [3:0]  op;
    logic [3:0]  waddr0;
    logic        we0;
    logic [3:0]  raddr0;
    logic [3:0]  raddr1;
    logic [15:0] imm;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic        pend       = 1'b0;
    logic [15:0] paddr      = 16'h0000;
    logic        delay_resp = 1'b0;
    logic        spur       = 1'b0;

    always #5 clk = ~clk;

    yd_fetch_decode dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .jpc_o      (jpc_o),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .stall_i    (stall_i),
        .br_done_i  (br_done_i),
        .dec_valid  (dec_valid),
        .dec_pc     (dec_pc),
        .op         (op),
        .waddr0     (waddr0),
        .we0        (we0),
        .raddr0     (raddr0),
        .raddr1     (raddr1),
        .imm        (imm)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_resp();
        imem_valid = (pend & ~delay_resp) | spur;
        imem_data  = spur ? 16'h5FFF : mem[paddr[7:0]];
    endtask

    // One clock: sample handshakes at the falling edge, then update the
    // memory response and the PC register model just after the rising edge.
    task automatic tick();
        logic        acc;
        logic        dlv;
        logic        adv;
        logic [15:0] a;
        @(negedge clk);
        acc = imem_req & imem_ready;
        a   = imem_addr;
        dlv = pend & ~delay_resp;
        adv = ~jpc_o;
        @(posedge clk);
        #1;
        if (dlv) pend = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            paddr = a;
        end
        if (adv) pc_i = pc_i + 16'd1;
        drive_resp();
        #1;
    endtask

    task automatic wait_dec();
        int n = 0;
        while (dec_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk("dec_timeout", dec_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'h71, 8'(i)};
        mem[0]     = 16'h1234;
        mem[1]     = 16'h2345;
        mem[2]     = 16'hE3F6;
        mem[3]     = 16'h0000;
        mem[8'h21] = 16'h5F12;
        mem[8'h41] = 16'h1F00;

        // ---------------- reset state ----------------
        rst = 1'b0; pc_i = 16'h0000; imem_ready = 1'b0; stall_i = 1'b0;
        br_done_i = 1'b0; imem_valid = 1'b0; imem_data = 16'h0000;
        #3;
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_jpc", jpc_o, 1'b1);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_dec_pc", dec_pc, 16'h0000);
        chk("rst_op", op, 4'h0);
        chk("rst_imm", imm, 16'h0000);
        imem_ready = 1'b1;
        #1;
        chk("rst_jpc_ready", jpc_o, 1'b1);
        tick();

        // ---------------- streaming and latency ----------------
        rst = 1'b1;
        #1;
        chk("s_req0", imem_req, 1'b1);
        chk("s_jpc0", jpc_o, 1'b0);
        chk("s_addr0", imem_addr, 16'h0000);
        tick();
        chk("s_jpc1", jpc_o, 1'b0);
        chk("s_early1", dec_valid, 1'b0);
        tick();
        chk("s_early2", dec_valid, 1'b0);
        chk("s_pc2", pc_i, 16'h0002);
        tick();
        chk("s_valid", dec_valid, 1'b1);
        chk("s_op", op, 4'h1);
        chk("s_waddr0", waddr0, 4'h2);
        chk("s_raddr0", raddr0, 4'h3);
        chk("s_raddr1", raddr1, 4'h4);
        chk("s_we0", we0, 1'b1);
        chk("s_pc0", dec_pc, 16'h0000);
        chk("s_imm0", imm, 16'h0000);
        tick(); wait_dec();
        chk("s_pc1", dec_pc, 16'h0001);
        chk("s_op1", op, 4'h2);
        tick(); wait_dec();
        chk("ldi_pc", dec_pc, 16'h0002);
        chk("ldi_op", op, 4'hE);
        chk("ldi_waddr0", waddr0, 4'h3);
        chk("ldi_imm", imm, 16'hFFF6);
        chk("ldi_we0", we0, 1'b1);
        tick(); wait_dec();
        chk("nop_pc", dec_pc, 16'h0003);
        chk("nop_we0", we0, 1'b0);
        chk("nop_imm", imm, 16'h0000);

        // ---------------- stall: queue fills, PC freezes ----------------
        stall_i = 1'b1;
        repeat (5) tick();
        chk("st_req", imem_req, 1'b0);
        chk("st_jpc", jpc_o, 1'b1);
        chk("st_pc", pc_i, 16'h0006);
        chk("st_hold_valid", dec_valid, 1'b1);
        chk("st_hold_pc", dec_pc, 16'h0003);
        stall_i = 1'b0;
        for (int i = 4; i < 8; i++) begin
            tick(); wait_dec();
            chk("rel_pc", dec_pc, 16'(i));
            chk("rel_raddr1", raddr1, 4'(i));
        end

        // ---------------- async reset mid-stream ----------------
        #1; rst = 1'b0; #1;
        chk("rs_valid", dec_valid, 1'b0);
        chk("rs_dec_pc", dec_pc, 16'h0000);
        chk("rs_op", op, 4'h0);
        chk("rs_raddr1", raddr1, 4'h0);
        chk("rs_req", imem_req, 1'b0);
        chk("rs_jpc", jpc_o, 1'b1);
        pend = 1'b0; delay_resp = 1'b0; spur = 1'b0; drive_resp();
        pc_i = 16'h0020; stall_i = 1'b1;
        tick();

        // ---------------- branch with fetch in flight ----------------
        rst = 1'b1;
        #1;
        chk("b_req", imem_req, 1'b1);
        tick(); tick(); tick();
        chk("b_x_valid", dec_valid, 1'b1);
        chk("b_x_pc", dec_pc, 16'h0020);
        delay_resp = 1'b1; drive_resp();
        tick();
        chk("b_full_req", imem_req, 1'b0);
        chk("b_full_jpc", jpc_o, 1'b1);
        chk("b_full_pc", pc_i, 16'h0023);
        stall_i = 1'b0; br_done_i = 1'b1;
        tick();
        br_done_i = 1'b0;
        chk("b_pc", dec_pc, 16'h0021);
        chk("b_op", op, 4'h5);
        chk("b_waddr0", waddr0, 4'hF);
        chk("b_we0", we0, 1'b1);
        chk("b_raddr0", raddr0, 4'h1);
        chk("b_raddr1", raddr1, 4'h2);
        chk("b_req", imem_req, 1'b0);
        chk("b_jpc", jpc_o, 1'b1);
        delay_resp = 1'b0; drive_resp();
        #1;
        chk("b_jpc_resp", jpc_o, 1'b1);
        tick();
        chk("b_drop_valid", dec_valid, 1'b0);
        chk("b_hold_req", imem_req, 1'b0);
        chk("b_hold_jpc", jpc_o, 1'b1);
        pc_i = 16'h0040; br_done_i = 1'b1;
        tick();
        br_done_i = 1'b0;
        #1;
        chk("b_resume_req", imem_req, 1'b1);
        chk("b_resume_jpc", jpc_o, 1'b0);
        chk("b_resume_addr", imem_addr, 16'h0040);
        tick(); wait_dec();
        chk("b_new_pc", dec_pc, 16'h0040);
        chk("b_new_op", op, 4'h7);
        chk("b_new_raddr1", raddr1, 4'h0);
        tick(); wait_dec();
        chk("b2_pc", dec_pc, 16'h0041);
        chk("b2_op", op, 4'h1);
        chk("b2_waddr0", waddr0, 4'hF);
        tick();
        chk("b2_req", imem_req, 1'b0);
        chk("b2_jpc", jpc_o, 1'b1);

        // ---------------- async reset mid-BRANCH ----------------
        #1; rst = 1'b0; #1;
        chk("rb_valid", dec_valid, 1'b0);
        chk("rb_waddr0", waddr0, 4'h0);
        chk("rb_op", op, 4'h0);
        chk("rb_req", imem_req, 1'b0);
        chk("rb_jpc", jpc_o, 1'b1);
        pend = 1'b0; delay_resp = 1'b0; spur = 1'b0; drive_resp();
        pc_i = 16'h0050; imem_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rr_req", imem_req, 1'b1);
        chk("rr_jpc", jpc_o, 1'b1);

        // ---------------- ready low 3 cycles, spurious valid ----------------
        tick();
        spur = 1'b1; drive_resp();
        tick();
        spur = 1'b0; drive_resp();
        tick();
        chk("nr_jpc", jpc_o, 1'b1);
        chk("nr_pc", pc_i, 16'h0050);
        chk("nr_valid", dec_valid, 1'b0);
        imem_ready = 1'b1;
        #1;
        chk("nr_jpc_go", jpc_o, 1'b0);
        tick(); wait_dec();
        chk("nr_pc50", dec_pc, 16'h0050);
        chk("nr_op50", op, 4'h7);
        tick(); wait_dec();
        chk("nr_pc51", dec_pc, 16'h0051);
        chk("nr_raddr1", raddr1, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/yd_fetch_decode.md
Name: yd_fetch_decode

Overview:
Instruction fetch/decode stage directly upstream of the register file. It drives the register-file jpc (PC hold) input, fetches 16-bit instructions from instruction memory at the register-file PC, and buffers them in a 2-entry queue. It decodes each instruction into the register-file read/write addresses for the execute stage. It also owns the PC-write (branch) bubble.

Parameters:
QDEPTH, 2, instruction queue entries (power of 2, ≥2)
NOP_OP, 4'h0, opcode with no register write
LDI_OP, 4'hE, opcode whose low byte is a sign-extended immediate

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
pc_i  in  16  current PC from register file
jpc_o  out  1  to register-file jpc; 1 = PC holds, 0 = PC increments this edge
imem_addr  out  16  fetch address (= pc_i)
imem_req  out  1  fetch request
imem_ready  in  1  memory accepts request this cycle
imem_data  in  16  fetched instruction
imem_valid  in  1  imem_data valid (response to oldest accepted request)
stall_i  in  1  execute stage cannot take a new instruction
br_done_i  in  1  execute has written PC (pulse)
dec_valid  out  1  decoded outputs valid
dec_pc  out  16  PC of decoded instruction
op  out  4  instr[15:12]
waddr0  out  4  instr[11:8]
we0  out  1  op != NOP_OP
raddr0  out  4  instr[7:4]
raddr1  out  4  instr[3:0]
imm  out  16  sign-extended instr[7:0] if op==LDI_OP, else 0

Behaviour:
- Reset (rst=0, async): queue empty, no outstanding fetch, state FETCH, dec_valid=0, all decoded outputs 0. jpc_o=1 while rst=0.
- One outstanding fetch max. Slots reserved = queue count + outstanding.
- imem_req = (state==FETCH) & (slots reserved < QDEPTH) & ~(imem_valid discard pending).
- Accept = imem_req & imem_ready. jpc_o = ~accept, so PC advances exactly once per accepted fetch. The PC of an accepted fetch is tagged with the entry (pc_i at accept).
- Response: imem_valid writes {imem_data, tagged pc} into queue tail the same edge. Outstanding clears. Accept and response may occur in the same cycle.
- Decode register: loads queue head when ~dec_valid | ~stall_i and the queue is non-empty. Otherwise it holds. dec_valid drops when the head is consumed and the queue is empty. A full queue with stall_i=1 stops requests and holds the PC via jpc_o=1.
- Latency: request accepted at cycle N, imem_valid at N+1 → dec_valid at N+2 if the queue was empty and there is no stall.
- Branch: a loaded instruction with we0=1 & waddr0==4'hF moves state FETCH→BRANCH on the load edge.
  - All younger queue entries are flushed.
  - Any outstanding fetch is marked discard; its response is dropped, not queued.
  - In BRANCH: imem_req=0, jpc_o=1 continuously, so the register file accepts the PC write.
  - br_done_i=1 → FETCH next edge, and fetch resumes from the new pc_i.
  - br_done_i arriving in the same cycle as the branch load is ignored; at least one BRANCH cycle occurs.
- imem_valid with nothing outstanding is ignored. Queue overflow is impossible by the reservation rule. Pointers wrap modulo QDEPTH.
- Reset mid-operation clears everything, including the discard flag. The first request after rst rises uses pc_i.

Test Plan:
- Reset, then pc_i=0 and imem_ready=imem_valid=1 streaming 16'h1234, 16'h2345 → jpc_o low each cycle. dec_valid at cycle 2 with op=1, waddr0=2, raddr0=3, raddr1=4, we0=1, dec_pc=0, then dec_pc=1.
- Instruction 16'hE3F6 → op=E, waddr0=3, imm=16'hFFF6. Instruction 16'h0000 → we0=0, imm=0.
- stall_i=1 for 5 cycles while streaming → after 2 queued plus 1 decoded: imem_req=0, jpc_o=1, and PC frozen. Release → instructions delivered in order with no loss or duplication.
- Decode 16'h5F12 (branch) while a fetch is outstanding and the queue holds 1 entry → queue flushed, response dropped, jpc_o=1 until br_done_i. Next fetch at the new pc_i=16'h0040 yields dec_pc=16'h0040.
- imem_ready low for 3 cycles → jpc_o=1 for those 3 cycles, no duplicate fetch. Also drive imem_valid with nothing outstanding → queue unchanged.
- Assert rst=0 asynchronously mid-stream and mid-BRANCH → outputs clear immediately. After release, fetch restarts in FETCH state.
